// File: rtl/demux_pkg.sv
// demux_pkg: shared constants for the 1-to-4 operand load distributor.
//   LANE_A..LANE_D : lane indices matching the in_dest encoding
//   LANE_DEPTH     : entries per lane buffer (also the "full" level value)
package demux_pkg;

    localparam int LANE_A = 0;
    localparam int LANE_B = 1;
    localparam int LANE_C = 2;
    localparam int LANE_D = 3;

    localparam logic [1:0] LANE_DEPTH = 2'd2;

endpackage

// File: rtl/demux_lane_fifo.sv
// demux_lane_fifo: one 2-entry lane buffer (head register, tail register,
// occupancy 0..2). The head register is presented directly as the lane output.
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset (clears level and data)
//   CE         in   clock enable; low freezes all state
//   push       in   write push_data this edge (never asserted when full)
//   push_data  in   WIDTH-bit word to write
//   pop        in   consume the head this edge (only when head_valid)
//   head_data  out  head register
//   head_valid out  level != 0
//   level      out  occupancy 0..2
module demux_lane_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = 48
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       level
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_level;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= 2'd0;
        end else if (CE) begin
            case (r_level)
                2'd0: begin
                    if (push) begin
                        r_head  <= push_data;
                        r_level <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        // Old head leaves as the new word takes its place.
                        r_head <= push_data;
                    end else if (push) begin
                        r_tail  <= push_data;
                        r_level <= LANE_DEPTH;
                    end else if (pop) begin
                        r_level <= 2'd0;
                    end
                end
                2'd2: begin
                    // The top never pushes into a full lane.
                    if (pop) begin
                        r_head  <= r_tail;
                        r_level <= 2'd1;
                    end
                end
                default: r_level <= 2'd0;
            endcase
        end
    end

    assign head_data  = r_head;
    assign head_valid = (r_level != 2'd0);
    assign level      = r_level;

endmodule

// File: rtl/demux1x4_router.sv
// demux1x4_router: registered 1-to-4 distributor. One tagged word per cycle is
// steered into one of four independent 2-deep lane buffers (A, B, C, D), each
// drained by its own valid/ready consumer. A full destination lane stalls the
// whole input (head-of-line blocking, no reordering across lanes).
// Ports:
//   CLK, RST, CE      clock, sync active-high reset, clock enable
//   in_data/in_dest   word and 2-bit destination lane
//   in_valid/in_ready producer handshake (in_ready is combinational)
//   out_data          lane i head at [i*WIDTH +: WIDTH]
//   out_valid         per-lane head valid
//   out_ready         per-lane consumer ready
//   lane_level        {L3,L2,L1,L0}, 2 bits each, occupancy 0..2
module demux1x4_router
    import demux_pkg::*;
#(
    parameter int WIDTH = 48
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CE,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_dest,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [7:0]         lane_level
);

    logic [3:0] w_push;
    logic [3:0] w_pop;
    logic [3:0] w_valid;
    logic [1:0] w_level [4];

    // Space freed by a same-cycle pop is deliberately not borrowed.
    assign in_ready  = CE & (w_level[in_dest] != LANE_DEPTH);
    assign out_valid = w_valid;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign w_push[i] = CE & in_valid & in_ready & (in_dest == 2'(i));
        assign w_pop[i]  = CE & w_valid[i] & out_ready[i];

        demux_lane_fifo #(.WIDTH(WIDTH)) u_fifo (
            .CLK        (CLK),
            .RST        (RST),
            .CE         (CE),
            .push       (w_push[i]),
            .push_data  (in_data),
            .pop        (w_pop[i]),
            .head_data  (out_data[i*WIDTH +: WIDTH]),
            .head_valid (w_valid[i]),
            .level      (w_level[i])
        );

        assign lane_level[2*i +: 2] = w_level[i];
    end

endmodule

// File: doc/demux1x4_router.md
# demux1x4_router

Registered 1-to-4 distributor for the DSP48A1 datapath, the write-side counterpart of the 4:1 operand selector. It accepts one WIDTH-bit word per cycle, tagged with a 2-bit destination, and steers it into one of four independent 2-deep lane buffers, each drained by its own valid/ready consumer. It feeds the per-port operand registers (A, B, C, D) from a single shared load bus.

## Interface
- WIDTH, 48, data width of the input word and of every lane output
- CLK  in  1  sole clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- CE  in  1  clock enable; when low, all state is frozen
- in_data  in  WIDTH  word to route
- in_dest  in  2  destination lane: 0=A, 1=B, 2=C, 3=D
- in_valid  in  1  producer has a word on in_data/in_dest
- in_ready  out  1  combinational; the word is accepted on an edge where in_valid & in_ready
- out_data  out  4*WIDTH  lane i at bits [i*WIDTH +: WIDTH]; head of lane i buffer
- out_valid  out  4  lane i head is valid
- out_ready  in  4  consumer i takes its head on an edge where out_valid[i] & out_ready[i]
- lane_level  out  8  2 bits per lane, {L3,L2,L1,L0}; occupancy 0..2

## Operation
- Each lane is an independent 2-entry FIFO with a head register, a tail register, and an occupancy count in 0..2.
- Push to lane i: CE & in_valid & in_ready & in_dest==i.
- Pop from lane i: CE & out_valid[i] & out_ready[i].
- in_ready = CE & (level[in_dest] != 2).
  - Space is never borrowed from a same-cycle pop. A full lane stalls the input even when out_ready is high.
  - in_ready depends on in_dest, not on in_valid.
- A push stalled on a full lane blocks the whole input. There is no reordering across lanes; head-of-line blocking is intended.
- Lane occupancy transitions:
  - level 0, push: word goes to head; level becomes 1.
  - level 1, push only: word goes to tail; level becomes 2.
  - level 1, pop only: level becomes 0.
  - level 1, push and pop together: head takes the new word; level stays 1.
  - level 2, pop: head takes the tail word; level becomes 1. A push cannot occur at level 2.
- out_valid[i] = (level_i != 0). out_data lane i is always the head register.
- Per-lane order is strictly FIFO. Lanes are fully independent: any subset may pop in the same cycle as any push.
- CE low: no push, no pop, registers hold. out_valid and out_data keep their values; out_ready is ignored.
- Contents of empty data slots are don't-care, but must be reset to 0 so X never propagates.

## Timing
- Reset, synchronous: on an edge with RST=1, all levels go to 0, out_valid=4'b0000, out_data=0, and lane_level=0. in_ready is then high whenever CE=1.
  - RST takes priority over CE and over any handshake in the same cycle.
  - Words held at reset are discarded.
- Latency: a word accepted at edge N appears on out_data with out_valid high immediately after edge N, so a consumer can pop it at edge N+1.
- Throughput: one push per cycle overall. Each lane sustains one word per cycle when its consumer holds out_ready high.
- in_dest and in_data are sampled only at the accepting edge. The producer may change them freely while in_ready is low.

## Structure
- Shared package demux_pkg:
  - lane index localparams LANE_A=0, LANE_B=1, LANE_C=2, LANE_D=3
  - LANE_DEPTH=2
- One sub-module: demux_lane_fifo.
  - Parameter: WIDTH.
  - Ports: CLK, RST, CE, push, push_data, pop, head_data, head_valid, level.
  - It is instantiated four times by a generate loop.
- The top level holds only the destination decode and the in_ready mux.

## Test plan
- Reset, then push 0x000000000011 to dest 2 with out_ready=0. Required: out_valid=4'b0100, lane C data 0x11, lane_level=8'b00010000.
- Push 0x1, then 0x2, to dest 0 with out_ready[0]=0. Required: L0=2 and in_ready=0 for dest 0, in_ready=1 for dest 1. Then set out_ready[0]=1. Required: pops return 0x1, then 0x2, then out_valid[0]=0.
- Lane B at level 1, with a push of 0xAB and a pop in the same cycle. Required: L1 stays 1, head becomes 0xAB, the old head is consumed.
- Streaming: out_ready=4'hF, with dests cycling 0,1,2,3 and data 0..7 over 8 consecutive cycles. Required: in_ready is never low, and each lane delivers its 2 words in order.
- CE=0 for 3 cycles while in_valid=1 and out_ready=4'hF with lanes non-empty. Required: in_ready=0 and all levels and data unchanged. After CE returns high, draining resumes.
- Assert RST with all lanes full and in_valid=1. Required: after the edge, levels are all 0, out_valid=0 and out_data=0, and the word offered in the reset cycle is not stored.
